// File: rtl/alu_seq_ctrl_if.sv
// Command, ALU and result signal bundle for alu_seq_ctrl; slave is the sequencer
// side, master is the command source / result consumer / ALU side.
interface alu_seq_ctrl_if #(
  parameter int W  = 16,
  parameter int CW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [W-1:0]  cmd_a;
  logic [W-1:0]  cmd_b;
  logic [CW-1:0] cmd_count;
  logic          abort;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [2:0]    alu_op;
  logic [W-1:0]  alu_y;
  logic          alu_en;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_data;
  logic [CW-1:0] res_iters;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_count, abort, alu_y, res_ready,
    output cmd_ready, alu_a, alu_b, alu_op, alu_en, res_valid, res_data, res_iters
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_count, abort, alu_y, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_op, alu_en, res_valid, res_data, res_iters
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Iterates one ALU op cmd_count times (acc <- alu_y); result valid cmd_count+1 cycles after accept.
// Result held stable under res_ready backpressure; no new command until back in IDLE.
module alu_seq_ctrl #(
  parameter int W  = 16,
  parameter int CW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  typedef struct packed {
    logic [2:0]    op;
    logic [W-1:0]  b;
    logic [CW-1:0] count;
  } cmd_t;

  state_e        state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          alu_en_q, alu_en_d;
  logic          res_valid_q, res_valid_d;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        // abort is deliberately not looked at here: an accept always wins
        if (bus.cmd_valid) begin
          cmd_d   = '{op: bus.cmd_op, b: bus.cmd_b, count: bus.cmd_count};
          acc_d   = bus.cmd_a;
          rem_d   = bus.cmd_count;
          state_d = (bus.cmd_count == '0) ? DONE : EXEC;
        end
      end
      EXEC: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          acc_d = bus.alu_y;
          rem_d = rem_q - 1'b1;
          if (rem_q == CW'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.abort || bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    alu_en_d    = (state_d == EXEC);
    res_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      alu_en_q    <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      alu_en_q    <= alu_en_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.alu_a     = acc_q;
  assign bus.alu_b     = cmd_q.b;
  assign bus.alu_op    = cmd_q.op;
  assign bus.alu_en    = alu_en_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = acc_q;
  assign bus.res_iters = cmd_q.count;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomized and directed bench for alu_seq_ctrl against an arithmetic reference model.
module tb_alu_seq_ctrl;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  alu_seq_ctrl_if #(.W(16), .CW(8)) bus ();

  alu_seq_ctrl #(.W(16), .CW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ALU stub: add on op 110, pass A otherwise
  assign bus.alu_y = (bus.alu_op == 3'b110) ? bus.alu_a + bus.alu_b : bus.alu_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Value after i passes of the stubbed ALU starting from a
  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] op, input int i);
    logic [31:0] t;
    t = (op == 3'b110) ? 32'(a) + 32'(i) * 32'(b) : 32'(a);
    return t[15:0];
  endfunction

  task automatic drive_cmd(input logic [15:0] a, input logic [15:0] b,
                           input logic [2:0] op, input logic [7:0] cnt);
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_op    = op;
    bus.cmd_count = cnt;
    bus.cmd_valid = 1'b1;
  endtask

  // Called in the first cycle after the accept edge; returns in the first res_valid cycle.
  task automatic wait_result(input logic [15:0] a, input logic [15:0] b,
                             input logic [2:0] op, input logic [7:0] cnt);
    int lat;
    int en_cnt;
    lat    = 1;
    en_cnt = 0;
    while (!bus.res_valid && lat <= 300) begin
      chk("busy_cmd_ready", bus.cmd_ready, 0);
      if (bus.alu_en) begin
        chk("exec_alu_a", bus.alu_a, model(a, b, op, en_cnt));
        en_cnt++;
      end
      step();
      lat++;
    end
    chk("latency", lat, int'(cnt) + 1);
    chk("alu_en_cycles", en_cnt, cnt);
    chk("res_data", bus.res_data, model(a, b, op, cnt));
    chk("res_iters", bus.res_iters, cnt);
    chk("alu_b", bus.alu_b, b);
    chk("alu_op", bus.alu_op, op);
  endtask

  task automatic do_cmd(input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] op, input logic [7:0] cnt);
    drive_cmd(a, b, op, cnt);
    chk("accept_ready", bus.cmd_ready, 1);
    step();
    bus.cmd_valid = 1'b0;
    wait_result(a, b, op, cnt);
  endtask

  task automatic consume();
    bus.res_ready = 1'b1;
    step();
    chk("idle_cmd_ready", bus.cmd_ready, 1);
    chk("idle_res_valid", bus.res_valid, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    chk({tag, "_alu_a"}, bus.alu_a, 0);
    chk({tag, "_alu_b"}, bus.alu_b, 0);
    chk({tag, "_alu_op"}, bus.alu_op, 0);
    chk({tag, "_alu_en"}, bus.alu_en, 0);
    chk({tag, "_res_valid"}, bus.res_valid, 0);
    chk({tag, "_res_data"}, bus.res_data, 0);
    chk({tag, "_res_iters"}, bus.res_iters, 0);
  endtask

  initial begin
    logic [15:0] ra, rb, held;
    logic [2:0]  rop;
    logic [7:0]  rcnt;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_count = '0;
    bus.abort     = 1'b0;
    bus.res_ready = 1'b1;
    #12;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // Count loop, zero count, wrap
    do_cmd(16'h0000, 16'h0001, 3'b110, 8'd10);
    consume();
    do_cmd(16'h1234, 16'h0055, 3'b110, 8'd0);
    consume();
    do_cmd(16'hFFFE, 16'h0001, 3'b110, 8'd3);
    chk("wrap_value", bus.res_data, 16'h0001);
    consume();

    // Backpressure with a second command held on the input
    bus.res_ready = 1'b0;
    do_cmd(16'h0100, 16'h0010, 3'b110, 8'd4);
    held = bus.res_data;
    drive_cmd(16'hBEEF, 16'h0003, 3'b110, 8'd2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_res_valid", bus.res_valid, 1);
      chk("bp_res_data", bus.res_data, held);
      chk("bp_res_iters", bus.res_iters, 4);
      chk("bp_cmd_ready", bus.cmd_ready, 0);
      chk("bp_alu_b", bus.alu_b, 16'h0010);
      step();
    end
    bus.res_ready = 1'b1;
    step();
    chk("bp_idle_ready", bus.cmd_ready, 1);
    chk("bp_idle_valid", bus.res_valid, 0);
    step();
    bus.cmd_valid = 1'b0;
    wait_result(16'hBEEF, 16'h0003, 3'b110, 8'd2);
    consume();

    // Abort in the 5th EXEC cycle
    drive_cmd(16'h0007, 16'h0002, 3'b110, 8'd20);
    step();
    bus.cmd_valid = 1'b0;
    for (int i = 1; i < 5; i++) step();
    chk("abort_in_exec", bus.alu_en, 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_cmd_ready", bus.cmd_ready, 1);
    chk("abort_alu_en", bus.alu_en, 0);
    for (int i = 0; i < 25; i++) begin
      if (bus.res_valid) chk("abort_res_valid", bus.res_valid, 0);
      step();
    end
    chk("abort_still_idle", bus.cmd_ready, 1);

    // Abort together with an accept in IDLE: accept wins
    bus.abort = 1'b1;
    drive_cmd(16'h0ABC, 16'h0001, 3'b110, 8'd0);
    step();
    bus.abort = 1'b0;
    bus.cmd_valid = 1'b0;
    chk("abort_idle_accept", bus.res_valid, 1);
    chk("abort_idle_data", bus.res_data, 16'h0ABC);
    consume();

    // Async reset mid-EXEC
    drive_cmd(16'h1111, 16'h0001, 3'b110, 8'd50);
    step();
    bus.cmd_valid = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    #1;
    rst_n = 1'b1;
    step();
    chk("post_reset_valid", bus.res_valid, 0);
    do_cmd(16'h0005, 16'h0003, 3'b110, 8'd2);
    chk("post_reset_a2b", bus.res_data, 16'h000B);
    consume();

    // Max count
    do_cmd(16'h0000, 16'h0101, 3'b110, 8'd255);
    consume();

    // Randomized commands with random consumer stalls
    for (int n = 0; n < 30; n++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rop  = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b110;
      rcnt = 8'($urandom_range(0, 12));
      bus.res_ready = 1'b0;
      do_cmd(ra, rb, rop, rcnt);
      for (int s = $urandom_range(0, 3); s > 0; s--) begin
        step();
        chk("rnd_hold_valid", bus.res_valid, 1);
        chk("rnd_hold_data", bus.res_data, model(ra, rb, rop, rcnt));
      end
      consume();
      for (int s = $urandom_range(0, 2); s > 0; s--) step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
